// File: rtl/nibble_frame_demux_pkg.sv
// nibble_frame_demux_pkg: shared widths and slot counts for the nibble frame path.
package nibble_frame_demux_pkg;
    localparam int NUM_SLOTS = 4;
    localparam int IDX_W = 2;
    // Word width shared with the 4x1 selector so both ends agree.
    localparam int NIB_W = 4;
    typedef logic [IDX_W-1:0] slot_idx_t;
endpackage

// File: rtl/nibble_frame_demux_slot_index_counter.sv
// slot_index_counter: mod-4 slot pointer with increment, resync load-to-1 and async reset.
module slot_index_counter
    import nibble_frame_demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load1,
    output logic [IDX_W-1:0] idx,
    output logic             last
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idx <= '0;
        else if (load1)
            idx <= IDX_W'(1);
        else if (inc)
            idx <= idx + 1'b1;
    end

    assign last = idx == IDX_W'(NUM_SLOTS - 1);
endmodule

// File: rtl/nibble_frame_demux.sv
// nibble_frame_demux: steers a valid/ready nibble stream into four slots and
// publishes them together as one registered frame.
module nibble_frame_demux
    import nibble_frame_demux_pkg::*;
#(
    parameter int W = NIB_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [W-1:0]     DIN,
    input  logic             DIN_VALID,
    input  logic             DIN_FIRST,
    output logic             DIN_READY,
    output logic [W-1:0]     B0,
    output logic [W-1:0]     B1,
    output logic [W-1:0]     B2,
    output logic [W-1:0]     B3,
    output logic             FRAME_VALID,
    input  logic             FRAME_ACK,
    output logic [IDX_W-1:0] IDX,
    output logic             ERR_SYNC
);
    logic [W-1:0]     shadow [NUM_SLOTS-1];
    logic             last;
    logic             accept;
    logic             resync;
    logic             commit;
    logic [IDX_W-1:0] wr_slot;

    slot_index_counter u_idx (
        .clk  (CLK),
        .rst  (RESET),
        .inc  (accept && !DIN_FIRST),
        .load1(resync),
        .idx  (IDX),
        .last (last)
    );

    // Slot 3 stalls only while a published frame is still unacknowledged.
    always_comb begin
        DIN_READY = !(last && FRAME_VALID && !FRAME_ACK);
        accept    = DIN_VALID && DIN_READY;
        resync    = accept && DIN_FIRST;
        commit    = accept && !DIN_FIRST && last;
        wr_slot   = DIN_FIRST ? '0 : IDX;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_SLOTS - 1; i++)
                shadow[i] <= '0;
            B0          <= '0;
            B1          <= '0;
            B2          <= '0;
            B3          <= '0;
            FRAME_VALID <= 1'b0;
            ERR_SYNC    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS - 1; i++)
                if (accept && !commit && wr_slot == i[IDX_W-1:0])
                    shadow[i] <= DIN;
            if (commit) begin
                B0 <= shadow[0];
                B1 <= shadow[1];
                B2 <= shadow[2];
                B3 <= DIN;
            end
            // A commit on the acknowledge edge keeps the frame flag raised.
            FRAME_VALID <= commit || (FRAME_VALID && !FRAME_ACK);
            if (resync && IDX != '0)
                ERR_SYNC <= 1'b1;
        end
    end
endmodule

// File: tb/tb_nibble_frame_demux.sv
// tb_nibble_frame_demux: directed and randomized checks of nibble_frame_demux
// against a queue-based frame model.
module tb_nibble_frame_demux;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] DIN = '0;
    logic       DIN_VALID = 1'b0;
    logic       DIN_FIRST = 1'b0;
    logic       DIN_READY;
    logic [3:0] B0, B1, B2, B3;
    logic       FRAME_VALID;
    logic       FRAME_ACK = 1'b0;
    logic [1:0] IDX;
    logic       ERR_SYNC;

    int errors = 0;
    int checks = 0;

    logic [3:0]  cur [$];
    logic [15:0] m_frame = '0;
    logic        m_fv = 1'b0;
    logic        m_err = 1'b0;
    logic        ready_seen;
    logic        exp_ready;
    logic        acc;

    nibble_frame_demux #(.W(4)) dut (
        .CLK(CLK), .RESET(RESET), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .DIN_FIRST(DIN_FIRST), .DIN_READY(DIN_READY),
        .B0(B0), .B1(B1), .B2(B2), .B3(B3),
        .FRAME_VALID(FRAME_VALID), .FRAME_ACK(FRAME_ACK),
        .IDX(IDX), .ERR_SYNC(ERR_SYNC)
    );

    always #5 CLK = ~CLK;

    function automatic logic [19:0] dut_vec();
        return {B0, B1, B2, B3, FRAME_VALID, IDX, ERR_SYNC};
    endfunction

    function automatic logic [19:0] model_vec();
        return {m_frame, m_fv, 2'(cur.size()), m_err};
    endfunction

    task automatic model_reset();
        cur.delete();
        m_frame = '0;
        m_fv    = 1'b0;
        m_err   = 1'b0;
    endtask

    // One clock of stimulus; the model advances on the same edge as the DUT.
    task automatic step(input logic v, input logic [3:0] d, input logic f,
                        input logic a, output logic accepted);
        logic rdy;
        @(negedge CLK);
        DIN_VALID = v;
        DIN       = d;
        DIN_FIRST = f;
        FRAME_ACK = a;
        #1;
        ready_seen = DIN_READY;
        rdy = !(cur.size() == 3 && m_fv && !a);
        exp_ready = rdy;
        @(posedge CLK);
        accepted = v && rdy;
        if (m_fv && a) m_fv = 1'b0;
        if (accepted) begin
            if (f) begin
                if (cur.size() != 0) m_err = 1'b1;
                cur.delete();
            end
            cur.push_back(d);
            if (cur.size() == 4) begin
                m_frame = {cur[0], cur[1], cur[2], cur[3]};
                m_fv = 1'b1;
                cur.delete();
            end
        end
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (dut_vec() !== 20'h0 || DIN_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got %h ready=%b, want 00000 ready=1", dut_vec(), DIN_READY);
        end
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        step(0, 4'h0, 0, 0, acc);
        checks++;
        if (dut_vec() !== 20'h0) begin
            errors++;
            $display("FAIL reset_release: got %h, want 00000", dut_vec());
        end
    endtask

    task automatic test_basic();
        step(1, 4'h1, 1, 0, acc);
        step(1, 4'h2, 0, 0, acc);
        step(1, 4'h3, 0, 0, acc);
        checks++;
        if (B0 !== 4'h0 || FRAME_VALID !== 1'b0 || IDX !== 2'd3) begin
            errors++;
            $display("FAIL basic_partial: got B0=%h fv=%b idx=%0d, want 0 0 3", B0, FRAME_VALID, IDX);
        end
        step(1, 4'h4, 0, 0, acc);
        checks++;
        if (dut_vec() !== {16'h1234, 1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL basic_frame: got %h, want %h", dut_vec(), {16'h1234, 1'b1, 2'd0, 1'b0});
        end
    endtask

    task automatic test_backpressure();
        step(1, 4'hA, 1, 0, acc);
        step(1, 4'hB, 0, 0, acc);
        step(1, 4'hC, 0, 0, acc);
        checks++;
        if (ready_seen !== 1'b1) begin
            errors++;
            $display("FAIL bp_slot2_ready: got %b, want 1", ready_seen);
        end
        step(1, 4'hD, 0, 0, acc);
        checks++;
        if (ready_seen !== 1'b0 || exp_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_slot3_stall: got ready=%b, want 0", ready_seen);
        end
        checks++;
        if (dut_vec() !== {16'h1234, 1'b1, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL bp_hold: got %h, want %h", dut_vec(), {16'h1234, 1'b1, 2'd3, 1'b0});
        end
        step(1, 4'hD, 0, 1, acc);
        checks++;
        if (ready_seen !== 1'b1 || dut_vec() !== {16'hABCD, 1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL bp_ack_commit: got ready=%b %h, want ready=1 %h", ready_seen, dut_vec(), {16'hABCD, 1'b1, 2'd0, 1'b0});
        end
    endtask

    task automatic test_resync();
        step(1, 4'h5, 1, 1, acc);
        step(1, 4'h6, 0, 0, acc);
        step(1, 4'h7, 1, 0, acc);
        checks++;
        if (ERR_SYNC !== 1'b1 || IDX !== 2'd1 || FRAME_VALID !== 1'b0) begin
            errors++;
            $display("FAIL resync_err: got err=%b idx=%0d fv=%b, want 1 1 0", ERR_SYNC, IDX, FRAME_VALID);
        end
        step(1, 4'h8, 0, 0, acc);
        step(1, 4'h9, 0, 0, acc);
        step(1, 4'hE, 0, 0, acc);
        checks++;
        if (dut_vec() !== {16'h789E, 1'b1, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL resync_frame: got %h, want %h", dut_vec(), {16'h789E, 1'b1, 2'd0, 1'b1});
        end
        step(1, 4'h1, 0, 1, acc);
        step(1, 4'h2, 0, 0, acc);
        step(1, 4'h3, 0, 0, acc);
        step(1, 4'h4, 1, 0, acc);
        checks++;
        if (dut_vec() !== {16'h789E, 1'b0, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL first_at_slot3: got %h, want %h", dut_vec(), {16'h789E, 1'b0, 2'd1, 1'b1});
        end
        step(1, 4'h5, 0, 0, acc);
        step(1, 4'h6, 0, 0, acc);
        step(1, 4'h7, 0, 0, acc);
        checks++;
        if (dut_vec() !== {16'h4567, 1'b1, 2'd0, 1'b1} || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL after_slot3_resync: got %h, want %h", dut_vec(), {16'h4567, 1'b1, 2'd0, 1'b1});
        end
    endtask

    task automatic test_async_reset();
        step(1, 4'h3, 1, 1, acc);
        step(1, 4'h5, 0, 0, acc);
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== 20'h0 || DIN_READY !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got %h ready=%b, want 00000 ready=1", dut_vec(), DIN_READY);
        end
        RESET = 1'b0;
        model_reset();
        step(1, 4'hF, 0, 0, acc);
        step(1, 4'h0, 0, 0, acc);
        step(1, 4'hF, 0, 0, acc);
        step(1, 4'h0, 0, 0, acc);
        checks++;
        if (dut_vec() !== {16'hF0F0, 1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_frame: got %h, want %h", dut_vec(), {16'hF0F0, 1'b1, 2'd0, 1'b0});
        end
    endtask

    task automatic test_random_gaps();
        logic [3:0]  q [4];
        logic [19:0] prev;
        logic        a;
        int          t;
        repeat (8) begin
            foreach (q[k]) q[k] = 4'($urandom);
            for (int k = 0; k < 4; k++) begin
                repeat ($urandom_range(0, 3)) begin
                    prev = dut_vec();
                    a = 1'($urandom);
                    step(0, 4'($urandom), 1'($urandom), a, acc);
                    checks++;
                    if (dut_vec() !== model_vec() || (!prev[3] && dut_vec() !== prev)) begin
                        errors++;
                        $display("FAIL gap_hold: got %h, want %h (before %h)", dut_vec(), model_vec(), prev);
                    end
                end
                t = 0;
                acc = 1'b0;
                while (!acc && t < 16) begin
                    a = (t >= 8) ? 1'b1 : 1'($urandom);
                    step(1, q[k], k == 0, a, acc);
                    checks++;
                    if (ready_seen !== exp_ready) begin
                        errors++;
                        $display("FAIL rand_ready: got %b, want %b", ready_seen, exp_ready);
                    end
                    t++;
                end
                if (!acc) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_accept_timeout: nibble %0d not accepted in 16 cycles", k);
                end
            end
            checks++;
            if (dut_vec() !== model_vec() || {B0, B1, B2, B3} !== {q[0], q[1], q[2], q[3]} || FRAME_VALID !== 1'b1) begin
                errors++;
                $display("FAIL rand_frame: got %h fv=%b, want %h fv=1", {B0, B1, B2, B3}, FRAME_VALID, {q[0], q[1], q[2], q[3]});
            end
        end
        step(0, 4'h0, 0, 1, acc);
        prev = dut_vec();
        step(0, 4'h0, 0, 1, acc);
        checks++;
        if (dut_vec() !== prev || FRAME_VALID !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack: got %h, want %h", dut_vec(), prev);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_resync();
        test_async_reset();
        test_random_gaps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nibble_frame_demux.md
# nibble_frame_demux

Registered 1-to-4 frame demultiplexer: accepts a stream of 4-bit nibbles over a valid/ready handshake, steers them in order into four slots, and publishes all four slots together as one frame. It is the write side of the 4x1 nibble selection path. It fills the four parallel 4-bit words that the downstream selector later picks from by a 2-bit select, so those words never change mid-frame.

## Interface
Parameters:
- W, 4, nibble width in bits.

Ports:
- CLK  in  1  sole clock; all state on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- DIN  in  W  incoming nibble.
- DIN_VALID  in  1  DIN is valid this cycle.
- DIN_FIRST  in  1  qualifies DIN as slot 0 of a frame (resync marker); ignored unless accepted.
- DIN_READY  out  1  block can accept DIN this cycle.
- B0, B1, B2, B3  out  W each  published frame; Bn = nibble written to slot n.
- FRAME_VALID  out  1  B0..B3 hold an unacknowledged frame.
- FRAME_ACK  in  1  consumer has taken the frame.
- IDX  out  2  next slot to be written (0..3).
- ERR_SYNC  out  1  sticky: a DIN_FIRST arrived with IDX != 0.

## Operation
- Accept = DIN_VALID && DIN_READY, sampled at the rising edge.
- Slot writes:
  - An accepted nibble with DIN_FIRST=0 writes shadow slot IDX, then IDX increments mod 4.
  - An accepted nibble with DIN_FIRST=1 always writes shadow slot 0 and sets IDX to 1.
  - If IDX was not 0 at that moment, the partial frame is discarded and ERR_SYNC sets.
  - DIN_FIRST with IDX=0 is legal and raises no error.
- Commit: an accept at slot 3 copies shadow slots 0..2 plus the current DIN (as slot 3) into B0..B3, sets FRAME_VALID, and sets IDX to 0.
- FRAME_VALID clears on any edge where FRAME_VALID && FRAME_ACK, unless a commit occurs on the same edge. On that edge the commit wins: FRAME_VALID stays 1 and B0..B3 take the new frame.
- B0..B3 change only on a commit and are held otherwise, including after the acknowledge.
- DIN_READY = !(IDX==3 && FRAME_VALID && !FRAME_ACK). This is combinational; it is the only path from FRAME_ACK to an output.
  - Slots 0..2 are never back-pressured.
  - Slot 3 is back-pressured while an unacknowledged frame is pending, so published frames are never overwritten (no overrun possible).
- ERR_SYNC is cleared only by RESET.
- FRAME_ACK while FRAME_VALID=0 has no effect.

## Timing
- Reset values (immediate on RESET assertion, asynchronous):
  - B0..B3 = 0, FRAME_VALID = 0, IDX = 0, ERR_SYNC = 0, shadow slots = 0.
  - DIN_READY = 1.
- Latency: a slot-3 accept at edge k makes the new B0..B3 and FRAME_VALID=1 visible after edge k (1 cycle).
- Throughput: 1 nibble per cycle; with prompt acknowledgement, back-to-back frames every 4 cycles.
- IDX updates on the accepting edge and is registered.
- RESET mid-frame discards the partial frame and any pending frame; the first accept after release lands in slot 0.
- DIN_VALID=0 cycles in the middle of a frame hold IDX and the shadow slots indefinitely.
- If DIN_FIRST is asserted on a slot-3 position (IDX=3), the nibble is treated as a resync to slot 0 with ERR_SYNC set, not as a commit.

## Structure
- Shared package holds:
  - NUM_SLOTS = 4.
  - IDX_W = 2.
  - Default nibble width NIB_W = 4, shared with the 4x1 selector so both ends agree on word width.
- One natural sub-module: slot_index_counter, a mod-4 counter with increment, synchronous load-to-1 (resync) and async reset, producing IDX and a last-slot flag.
- Everything else (shadow slots, output registers, FRAME_VALID/ERR_SYNC flags, the ready equation) lives in the top level.

## Test plan
- Reset, then accept nibbles 0x1, 0x2, 0x3, 0x4 (first with DIN_FIRST) on consecutive cycles -> after 4th edge: B0..B3 = 1,2,3,4, FRAME_VALID=1, IDX=0, ERR_SYNC=0.
- With that frame pending, no ACK, send 0xA, 0xB, 0xC, then hold 0xD valid -> DIN_READY=0 at IDX=3, B0..B3 still 1,2,3,4. Assert FRAME_ACK -> 0xD accepted the same edge, B0..B3 = A,B,C,D, FRAME_VALID stays 1.
- Send 0x5, 0x6, then 0x7 with DIN_FIRST -> ERR_SYNC=1, IDX=1. Continue 0x8, 0x9, 0xE -> frame = 7,8,9,E.
- Accept 2 nibbles, assert RESET asynchronously between edges -> outputs 0 immediately, IDX=0. Next frame 0xF,0x0,0xF,0x0 publishes correctly.
- Inject random DIN_VALID gaps inside a frame -> published frame contents and order are unchanged versus the gapless run; FRAME_ACK with FRAME_VALID=0 changes nothing.
